// File: rtl/cpu_mem_responder.sv
// Single-port CPU memory responder: valid/ready request, registered response, byte-lane RAM.
// Define CPU_MEM_WAIT_EN to insert WAIT_CYCLES extra wait cycles before each access.
module cpu_mem_responder #(
  parameter int ADDR_BITS   = 12,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [31:0] i_req_addr,
  input  logic [2:0]  i_req_width,
  input  logic [31:0] i_req_wdata,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err
);

  localparam int WORDS = 2 ** (ADDR_BITS - 2);

  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait_cycles
    $error("cpu_mem_responder: WAIT_CYCLES must be in 0..15");
  end

`ifdef CPU_MEM_WAIT_EN
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;
  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);
  logic [3:0] r_wait_cnt;
`else
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;
`endif

  state_t                 r_state;
  logic                   r_req_ready;
  logic                   r_rsp_valid;
  logic [31:0]            r_rsp_rdata;
  logic                   r_rsp_err;
  logic                   r_we;
  logic                   r_err;
  logic [ADDR_BITS-1:0]   r_addr;
  logic [1:0]             r_width;
  logic [31:0]            r_wdata;
  logic [31:0]            r_mem [WORDS];

  logic                   w_req_err;
  logic                   w_mem_we;
  logic [3:0]             w_be;
  logic [31:0]            w_wlanes;
  logic [31:0]            w_rword;
  logic [31:0]            w_rsel;

  // Request is checked once, at acceptance, so later stages only see a single error bit.
  always_comb begin
    w_req_err = 1'b0;
    if (i_req_width >= 3'd3)                              w_req_err = 1'b1;
    if (i_req_width == 3'd1 && i_req_addr[0])             w_req_err = 1'b1;
    if (i_req_width == 3'd2 && i_req_addr[1:0] != 2'b00)  w_req_err = 1'b1;
    if (|i_req_addr[31:ADDR_BITS])                        w_req_err = 1'b1;
  end

  always_comb begin
    w_be     = 4'b1111;
    w_wlanes = r_wdata;
    case (r_width)
      2'd0: begin
        w_be     = 4'b0001 << r_addr[1:0];
        w_wlanes = {4{r_wdata[7:0]}};
      end
      2'd1: begin
        w_be     = r_addr[1] ? 4'b1100 : 4'b0011;
        w_wlanes = {2{r_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  assign w_mem_we = (r_state == S_ACCESS) && r_we && !r_err;
  assign w_rword  = r_mem[r_addr[ADDR_BITS-1:2]];

  always_comb begin
    w_rsel = w_rword;
    case (r_width)
      2'd0:    w_rsel = {24'd0, w_rword[{r_addr[1:0], 3'b000} +: 8]};
      2'd1:    w_rsel = {16'd0, (r_addr[1] ? w_rword[31:16] : w_rword[15:0])};
      default: ;
    endcase
  end

  // NOTE: the RAM array has no reset; its contents survive i_rst and only ACCESS writes it.
  always_ff @(posedge i_clk) begin
    if (w_mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[r_addr[ADDR_BITS-1:2]][8*b +: 8] <= w_wlanes[8*b +: 8];
      end
    end
  end

  // NOTE: all state and outputs use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_we        <= 1'b0;
      r_err       <= 1'b0;
      r_addr      <= '0;
      r_width     <= '0;
      r_wdata     <= '0;
`ifdef CPU_MEM_WAIT_EN
      r_wait_cnt  <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_req_valid && r_req_ready) begin
            r_we        <= i_req_we;
            r_err       <= w_req_err;
            r_addr      <= i_req_addr[ADDR_BITS-1:0];
            r_width     <= i_req_width[1:0];
            r_wdata     <= i_req_wdata;
            r_req_ready <= 1'b0;
`ifdef CPU_MEM_WAIT_EN
            r_wait_cnt  <= '0;
            r_state     <= (WAIT_CYCLES != 0) ? S_WAIT : S_ACCESS;
`else
            r_state     <= S_ACCESS;
`endif
          end
        end
`ifdef CPU_MEM_WAIT_EN
        S_WAIT: begin
          if (r_wait_cnt == WAIT_LAST) begin
            r_wait_cnt <= '0;
            r_state    <= S_ACCESS;
          end else begin
            r_wait_cnt <= r_wait_cnt + 4'd1;
          end
        end
`endif
        S_ACCESS: begin
          r_rsp_valid <= 1'b1;
          r_rsp_err   <= r_err;
          r_rsp_rdata <= (r_err || r_we) ? 32'd0 : w_rsel;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_req_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign o_req_ready = r_req_ready;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Directed bench for cpu_mem_responder: scoreboard of expected responses, latency, stall and reset checks.
// Latency is counted in rising edges starting with the acceptance edge itself.
module tb_cpu_mem_responder;

  localparam int ADDR_BITS   = 12;
  localparam int WAIT_CYCLES = 2;
`ifdef CPU_MEM_WAIT_EN
  localparam int EXP_LAT = 2 + WAIT_CYCLES;
`else
  localparam int EXP_LAT = 2;
`endif

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    string       tag;
  } exp_t;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_req_valid;
  logic        o_req_ready;
  logic        i_req_we;
  logic [31:0] i_req_addr;
  logic [2:0]  i_req_width;
  logic [31:0] i_req_wdata;
  logic        o_rsp_valid;
  logic        i_rsp_ready;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_err;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  cpu_mem_responder #(
    .ADDR_BITS  (ADDR_BITS),
    .WAIT_CYCLES(WAIT_CYCLES)
  ) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_req_valid(i_req_valid),
    .o_req_ready(o_req_ready),
    .i_req_we   (i_req_we),
    .i_req_addr (i_req_addr),
    .i_req_width(i_req_width),
    .i_req_wdata(i_req_wdata),
    .o_rsp_valid(o_rsp_valid),
    .i_rsp_ready(i_rsp_ready),
    .o_rsp_rdata(o_rsp_rdata),
    .o_rsp_err  (o_rsp_err)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".req_ready"}, {31'd0, o_req_ready}, 32'd1);
    check({tag, ".rsp_valid"}, {31'd0, o_rsp_valid}, 32'd0);
    check({tag, ".rsp_rdata"}, o_rsp_rdata, 32'd0);
    check({tag, ".rsp_err"},   {31'd0, o_rsp_err},   32'd0);
  endtask

  // Drive one request, wait (bounded) for the response and compare against the scoreboard.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [2:0] width,
                       input logic [31:0] wdata, input logic [31:0] exp_rdata,
                       input logic exp_err, input string tag);
    int   lat;
    exp_t e;
    sb.push_back('{rdata: exp_rdata, err: exp_err, tag: tag});
    @(negedge i_clk);
    check({tag, ".req_ready"}, {31'd0, o_req_ready}, 32'd1);
    i_req_valid = 1'b1;
    i_req_we    = we;
    i_req_addr  = addr;
    i_req_width = width;
    i_req_wdata = wdata;
    @(posedge i_clk);
    #1;
    i_req_valid = 1'b0;
    i_req_we    = 1'b0;
    i_req_addr  = '0;
    i_req_width = '0;
    i_req_wdata = '0;
    lat = 1;
    while (o_rsp_valid !== 1'b1 && lat < 64) begin
      @(posedge i_clk);
      #1;
      lat++;
    end
    check({tag, ".latency"}, 32'(lat), 32'(EXP_LAT));
    e = sb.pop_front();
    check({e.tag, ".rdata"}, o_rsp_rdata, e.rdata);
    check({e.tag, ".err"}, {31'd0, o_rsp_err}, {31'd0, e.err});
  endtask

  task automatic handshake(input string tag);
    @(negedge i_clk);
    i_rsp_ready = 1'b1;
    @(posedge i_clk);
    #1;
    i_rsp_ready = 1'b0;
    check({tag, ".hs_valid"}, {31'd0, o_rsp_valid}, 32'd0);
    check({tag, ".hs_ready"}, {31'd0, o_req_ready}, 32'd1);
  endtask

  task automatic xfer(input logic we, input logic [31:0] addr, input logic [2:0] width,
                      input logic [31:0] wdata, input logic [31:0] exp_rdata,
                      input logic exp_err, input string tag);
    issue(we, addr, width, wdata, exp_rdata, exp_err, tag);
    handshake(tag);
  endtask

  initial begin
    i_rst       = 1'b1;
    i_req_valid = 1'b0;
    i_req_we    = 1'b0;
    i_req_addr  = '0;
    i_req_width = '0;
    i_req_wdata = '0;
    i_rsp_ready = 1'b0;
    #1;
    check_reset_outputs("reset_t0");
    repeat (3) @(posedge i_clk);
    #1;
    check_reset_outputs("reset_held");
    @(negedge i_clk);
    i_rst = 1'b0;

    // Word write / read and sub-word reads
    xfer(1'b1, 32'h010, 3'd2, 32'hDEAD_BEEF, 32'h0,         1'b0, "wr32_010");
    xfer(1'b0, 32'h010, 3'd2, 32'h0,         32'hDEAD_BEEF, 1'b0, "rd32_010");
    xfer(1'b0, 32'h011, 3'd0, 32'h0,         32'h0000_00BE, 1'b0, "rd8_011");
    xfer(1'b0, 32'h012, 3'd1, 32'h0,         32'h0000_DEAD, 1'b0, "rd16_012");
    xfer(1'b1, 32'h013, 3'd0, 32'h55,        32'h0,         1'b0, "wr8_013");
    xfer(1'b0, 32'h010, 3'd2, 32'h0,         32'h55AD_BEEF, 1'b0, "rd32_010_b");

    // Lane masking with non-zero upper write-data bits
    xfer(1'b1, 32'h014, 3'd2, 32'h1122_3344, 32'h0,         1'b0, "wr32_014");
    xfer(1'b1, 32'h016, 3'd1, 32'hFFFF_CAFE, 32'h0,         1'b0, "wr16_016");
    xfer(1'b1, 32'h014, 3'd0, 32'hFFFF_FF99, 32'h0,         1'b0, "wr8_014");
    xfer(1'b0, 32'h014, 3'd2, 32'h0,         32'hCAFE_3399, 1'b0, "rd32_014");
    xfer(1'b0, 32'h014, 3'd1, 32'h0,         32'h0000_3399, 1'b0, "rd16_014");
    xfer(1'b0, 32'h017, 3'd0, 32'h0,         32'h0000_00CA, 1'b0, "rd8_017");

    // Rejected requests: no data, no side effect
    xfer(1'b0, 32'h011,  3'd1, 32'h0,         32'h0, 1'b1, "err_rd16_011");
    xfer(1'b1, 32'h012,  3'd2, 32'h1234_5678, 32'h0, 1'b1, "err_wr32_012");
    xfer(1'b1, 32'h013,  3'd1, 32'h0000_0000, 32'h0, 1'b1, "err_wr16_013");
    xfer(1'b0, 32'h000,  3'd3, 32'h0,         32'h0, 1'b1, "err_w3_000");
    xfer(1'b1, 32'h010,  3'd4, 32'h0,         32'h0, 1'b1, "err_w4_010");
    xfer(1'b0, 32'h1000, 3'd2, 32'h0,         32'h0, 1'b1, "err_rd_1000");
    xfer(1'b1, 32'h1010, 3'd2, 32'hFFFF_FFFF, 32'h0, 1'b1, "err_wr_1010");
    xfer(1'b0, 32'h010,  3'd2, 32'h0, 32'h55AD_BEEF, 1'b0, "rd32_010_after_err");

    // Response stall with a competing request held on the request port
    issue(1'b0, 32'h010, 3'd2, 32'h0, 32'h55AD_BEEF, 1'b0, "stall_rd");
    for (int i = 0; i < 5; i++) begin
      @(negedge i_clk);
      i_rsp_ready = 1'b0;
      i_req_valid = 1'b1;
      i_req_we    = 1'b1;
      i_req_addr  = 32'h010;
      i_req_width = 3'd2;
      i_req_wdata = 32'h0;
      check($sformatf("stall%0d.valid", i), {31'd0, o_rsp_valid}, 32'd1);
      check($sformatf("stall%0d.rdata", i), o_rsp_rdata, 32'h55AD_BEEF);
      check($sformatf("stall%0d.err", i),   {31'd0, o_rsp_err},   32'd0);
      check($sformatf("stall%0d.ready", i), {31'd0, o_req_ready}, 32'd0);
    end
    @(negedge i_clk);
    i_req_valid = 1'b0;
    i_req_we    = 1'b0;
    i_req_addr  = '0;
    i_req_width = '0;
    i_rsp_ready = 1'b1;
    @(posedge i_clk);
    #1;
    i_rsp_ready = 1'b0;
    check("stall.hs_valid", {31'd0, o_rsp_valid}, 32'd0);
    check("stall.hs_ready", {31'd0, o_req_ready}, 32'd1);
    xfer(1'b0, 32'h010, 3'd2, 32'h0, 32'h55AD_BEEF, 1'b0, "rd32_010_after_stall");

    // Reset while a write is pending cancels it; RAM contents survive reset
    xfer(1'b1, 32'h020, 3'd2, 32'hA5A5_A5A5, 32'h0, 1'b0, "wr32_020");
    @(negedge i_clk);
    i_req_valid = 1'b1;
    i_req_we    = 1'b1;
    i_req_addr  = 32'h020;
    i_req_width = 3'd2;
    i_req_wdata = 32'h0BAD_F00D;
    @(posedge i_clk);
    #1;
    i_req_valid = 1'b0;
    i_req_we    = 1'b0;
    i_req_addr  = '0;
    i_req_width = '0;
    i_req_wdata = '0;
    check("pend.ready_low", {31'd0, o_req_ready}, 32'd0);
    #2;
    i_rst = 1'b1;
    #1;
    check_reset_outputs("reset_mid");
    repeat (2) @(posedge i_clk);
    #1;
    check_reset_outputs("reset_mid_held");
    @(negedge i_clk);
    i_rst = 1'b0;
    xfer(1'b0, 32'h020, 3'd2, 32'h0, 32'hA5A5_A5A5, 1'b0, "rd32_020_after_reset");
    xfer(1'b0, 32'h010, 3'd2, 32'h0, 32'h55AD_BEEF, 1'b0, "rd32_010_after_reset");

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_mem_responder.md
CPU_MEM_RESPONDER -- requirements
Module: cpu_mem_responder

Interface
REQ-001 Parameter ADDR_BITS, default 12, meaning byte-address width of the internal RAM (2^ADDR_BITS bytes, organised as 32-bit words).
REQ-002 Parameter WAIT_CYCLES, default 2, meaning extra access wait cycles, range 0..15.
REQ-003 i_clk  input  1  clock; every flop updates on its rising edge.
REQ-004 i_rst  input  1  reset, asynchronous, active-high.
REQ-005 i_req_valid  input  1  CPU request present.
REQ-006 o_req_ready  output  1  responder can accept a request.
REQ-007 i_req_we  input  1  1=write, 0=read.
REQ-008 i_req_addr  input  32  byte address.
REQ-009 i_req_width  input  3  data width code: 0=8, 1=16, 2=32, 3=64, 4=128 (3 and up are unsupported).
REQ-010 i_req_wdata  input  32  write data, right-justified.
REQ-011 o_rsp_valid  output  1  response present.
REQ-012 i_rsp_ready  input  1  CPU accepts the response.
REQ-013 o_rsp_rdata  output  32  read data, right-justified, zero-extended.
REQ-014 o_rsp_err  output  1  request rejected; no side effect.

Function
REQ-015 The FSM SHALL have four states, IDLE, WAIT, ACCESS and RESP, with o_req_ready=1 only in IDLE.
REQ-016 In IDLE, a request SHALL be accepted when i_req_valid and o_req_ready are both 1 on an edge: the request is latched, then the FSM moves to WAIT if WAIT_CYCLES>0, else to ACCESS.
REQ-017 WAIT SHALL count WAIT_CYCLES cycles and then move to ACCESS; request inputs are ignored outside IDLE.
REQ-018 ACCESS SHALL last one cycle, in which it performs the RAM read or the byte-lane-masked write, and then moves to RESP.
REQ-019 In RESP, o_rsp_valid=1 and o_rsp_rdata/o_rsp_err SHALL remain stable until an edge with i_rsp_ready=1, after which the FSM returns to IDLE.
REQ-020 Latency: o_rsp_valid SHALL rise 2+WAIT_CYCLES edges after the acceptance edge.
REQ-021 Memory SHALL be little-endian: a byte access uses lane addr[1:0], a 16-bit access uses lanes addr[1]*2+{0,1}, and a 32-bit access uses all four lanes.
REQ-022 An error SHALL be flagged for any of the following: width code >=3; a 16-bit access with addr[0]=1; a 32-bit access with addr[1:0]!=0; addr >= 2^ADDR_BITS.
REQ-023 On error, o_rsp_err=1, o_rsp_rdata=0, and the RAM SHALL NOT be written; the response still follows the normal FSM timing.
REQ-024 For a read, o_rsp_rdata SHALL carry the selected lanes right-justified, with upper bits 0.
REQ-025 For a write, o_rsp_rdata SHALL be 0 and o_rsp_err SHALL be 0 unless REQ-022 applies.
REQ-026 Back-to-back operation: after the RESP handshake edge, o_req_ready=1 in the following cycle, so a new request can be accepted no earlier than one cycle after the handshake.
REQ-027 Read-after-write to the same address SHALL return the newly written data.

Reset
REQ-028 While i_rst is asserted, the FSM SHALL be in IDLE, with o_req_ready=1, o_rsp_valid=0, o_rsp_rdata=0, o_rsp_err=0, and the wait counter=0.
REQ-029 Reset asserted before the ACCESS edge SHALL cancel the pending request with no RAM write.
REQ-030 Reset SHALL NOT clear RAM contents.

Configuration
REQ-031 With macro CPU_MEM_WAIT_EN defined, WAIT_CYCLES SHALL be honoured as in REQ-016 to REQ-020.
REQ-032 Without CPU_MEM_WAIT_EN, the WAIT state and its counter SHALL be omitted, IDLE SHALL go directly to ACCESS, latency SHALL be fixed at 2, and WAIT_CYCLES SHALL be ignored.

Verification
REQ-033 Write 32-bit 0xDEADBEEF to 0x010, then read 32-bit 0x010 -> rdata=0xDEADBEEF, err=0, valid exactly 2+WAIT_CYCLES edges after each accept.
REQ-034 Read byte 0x011, then 16-bit read of 0x012 -> 0x000000BE and 0x0000DEAD.
REQ-035 Write byte 0x55 to 0x013, then read 32-bit 0x010 -> 0x55ADBEEF (the other lanes are unchanged).
REQ-036 16-bit read at 0x011; 32-bit write at 0x012; width=3 read at 0x0; read at 0x1000 with ADDR_BITS=12 -> err=1 and rdata=0 in each case, and a 32-bit read of 0x010 afterwards is unchanged.
REQ-037 Hold i_rsp_ready=0 for 5 cycles during RESP -> valid, data and err stable, o_req_ready=0, and a new i_req_valid is not accepted until the handshake.
REQ-038 Assert i_rst during WAIT of a write to 0x020 -> outputs at reset values, 0x020 keeps its prior value; with CPU_MEM_WAIT_EN undefined, latency is 2 regardless of WAIT_CYCLES.
